prbs_checker: RTL and testbench

- Parametrised PRBS receiver-side checker; counterpart and successor to the PRBS31 generator.
- Accepts one WORDWIDTH-bit word per clock, LSB = earliest bit, and supports four run-time-selectable polynomials.
- Self-synchronises to the incoming stream, then free-runs a local reference. Counts bit errors (saturating) and tracks lock with a hunt/locked state machine.
- Sits at the ETROC2 readout serializer/link test path for PRBS link qualification.

---
 rtl/prbs_pkg.sv | 40 ++++
 rtl/prbs_next_word.sv | 38 +++
 rtl/prbs_checker.sv | 130 +++++++++++++
 tb/tb_prbs_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker: polynomial selection, tap table,
// lock FSM states and small sizing helpers.
package prbs_pkg;

    localparam int HISTW = 31;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Recurrence b[n] = b[n-n_tap] ^ b[n-m_tap]
    typedef struct packed {
        logic [4:0] n;
        logic [4:0] m;
    } taps_t;

    function automatic taps_t mode_taps(input logic [1:0] mode);
        taps_t t;
        case (mode)
            MODE_PRBS7:  t = '{n: 5'd7,  m: 5'd6};
            MODE_PRBS15: t = '{n: 5'd15, m: 5'd14};
            MODE_PRBS23: t = '{n: 5'd23, m: 5'd18};
            default:     t = '{n: 5'd31, m: 5'd28};
        endcase
        return t;
    endfunction

    function automatic int popcount_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/prbs_next_word.sv
// Combinational word-wide PRBS step: expected word from history, plus the
// history after shifting in either the reference bits or the expected bits.
module prbs_next_word
    import prbs_pkg::*;
#(
    parameter int WORDWIDTH = 15
) (
    input  logic [HISTW-1:0]     hist,
    input  logic [1:0]           mode,
    input  logic                 use_ref,
    input  logic [WORDWIDTH-1:0] ref_bits,
    output logic [WORDWIDTH-1:0] expected,
    output logic [HISTW-1:0]     hist_next
);

    localparam int SW = HISTW + WORDWIDTH;
    localparam int IW = $clog2(SW);

    // seq[0] is the oldest history bit; seq[HISTW+i] is bit i of this word.
    always_comb begin : unroll
        logic [SW-1:0] seq;
        logic [IW-1:0] idx_n;
        logic [IW-1:0] idx_m;
        taps_t         taps;
        taps     = mode_taps(mode);
        seq      = '0;
        expected = '0;
        seq[HISTW-1:0] = hist;
        for (int i = 0; i < WORDWIDTH; i++) begin
            idx_n = IW'(HISTW + i - int'(taps.n));
            idx_m = IW'(HISTW + i - int'(taps.m));
            expected[i]    = seq[idx_n] ^ seq[idx_m];
            seq[HISTW + i] = use_ref ? ref_bits[i] : expected[i];
        end
        hist_next = seq[SW-1 -: HISTW];
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises in HUNT, free-runs a local reference
// in LOCKED, and counts bit errors with a saturating counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WORDWIDTH   = 15,
    parameter int CNTWIDTH    = 16,
    parameter int LOCKCOUNT   = 4,
    parameter int UNLOCKCOUNT = 4
) (
    input  logic                 clkTMR,
    input  logic                 resetTMR,
    input  logic                 disTMR,
    input  logic [1:0]           modeTMR,
    input  logic                 clearTMR,
    input  logic [WORDWIDTH-1:0] dataTMR,
    output logic                 lockedTMR,
    output logic                 errFlagTMR,
    output logic [CNTWIDTH-1:0]  errCountTMR
);

    localparam int NW = popcount_width(WORDWIDTH);
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    lock_state_e          state_q, state_d;
    logic [HISTW-1:0]     hist_q, hist_d, hist_nxt;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           clean_q, clean_d, dirty_q, dirty_d;
    logic [7:0]           clean_inc, dirty_inc;
    logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic [WORDWIDTH-1:0] expected, mismatch;
    logic [NW-1:0]        nerr;
    logic [CNTWIDTH:0]    sum;

    // In HUNT the history follows the line; in LOCKED it follows itself.
    prbs_next_word #(.WORDWIDTH(WORDWIDTH)) u_next_word (
        .hist      (hist_q),
        .mode      (mode_q),
        .use_ref   (state_q == HUNT),
        .ref_bits  (dataTMR),
        .expected  (expected),
        .hist_next (hist_nxt)
    );

    assign mismatch  = dataTMR ^ expected;
    assign clean_inc = clean_q + 8'd1;
    assign dirty_inc = dirty_q + 8'd1;
    assign sum       = {1'b0, cnt_q} + (CNTWIDTH+1)'(nerr);

    always_comb begin
        nerr = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            nerr = nerr + NW'(mismatch[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        mode_d  = mode_q;
        clean_d = clean_q;
        dirty_d = dirty_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        if (modeTMR != mode_q) begin
            // New polynomial: drop lock, keep history and error count.
            state_d = HUNT;
            mode_d  = modeTMR;
            clean_d = '0;
            dirty_d = '0;
            flag_d  = 1'b0;
        end else begin
            hist_d = hist_nxt;
            case (state_q)
                HUNT: begin
                    flag_d = 1'b0;
                    if (nerr != '0) begin
                        clean_d = '0;
                    end else if (clean_inc == 8'(LOCKCOUNT)) begin
                        state_d = LOCKED;
                        clean_d = '0;
                        dirty_d = '0;
                    end else begin
                        clean_d = clean_inc;
                    end
                end
                LOCKED: begin
                    flag_d = (nerr != '0);
                    cnt_d  = sum[CNTWIDTH] ? CNT_MAX : sum[CNTWIDTH-1:0];
                    if (nerr == '0) begin
                        dirty_d = '0;
                    end else if (dirty_inc == 8'(UNLOCKCOUNT)) begin
                        state_d = HUNT;
                        dirty_d = '0;
                        clean_d = '0;
                    end else begin
                        dirty_d = dirty_inc;
                    end
                end
            endcase
            if (clearTMR) cnt_d = '0;
        end
    end

    always_ff @(posedge clkTMR) begin
        if (resetTMR) begin
            state_q <= HUNT;
            hist_q  <= '0;
            mode_q  <= modeTMR;
            clean_q <= '0;
            dirty_q <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else if (!disTMR) begin
            state_q <= state_d;
            hist_q  <= hist_d;
            mode_q  <= mode_d;
            clean_q <= clean_d;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    assign lockedTMR   = (state_q == LOCKED);
    assign errFlagTMR  = flag_q;
    assign errCountTMR = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: bit-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_prbs_checker;

    localparam int W = 15;

    logic          clk = 1'b0;
    logic          reset, dis, clear;
    logic [1:0]    mode;
    logic [W-1:0]  data;
    logic          locked16, flag16, locked8, flag8;
    logic [15:0]   cnt16;
    logic [7:0]    cnt8;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    prbs_checker #(.WORDWIDTH(W), .CNTWIDTH(16), .LOCKCOUNT(4), .UNLOCKCOUNT(4)) dut (
        .clkTMR(clk), .resetTMR(reset), .disTMR(dis), .modeTMR(mode),
        .clearTMR(clear), .dataTMR(data),
        .lockedTMR(locked16), .errFlagTMR(flag16), .errCountTMR(cnt16)
    );

    prbs_checker #(.WORDWIDTH(W), .CNTWIDTH(8), .LOCKCOUNT(4), .UNLOCKCOUNT(4)) dut8 (
        .clkTMR(clk), .resetTMR(reset), .disTMR(dis), .modeTMR(mode),
        .clearTMR(clear), .dataTMR(data),
        .lockedTMR(locked8), .errFlagTMR(flag8), .errCountTMR(cnt8)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit  mq[$];
    bit  tq[$];
    bit  m_locked, m_flag;
    int  m_clean, m_dirty, m_cnt16, m_cnt8, m_nerr;
    logic [1:0] m_mode;

    function automatic void taps_of(input logic [1:0] md, output int n, output int m);
        case (md)
            2'd0: begin n = 7;  m = 6;  end
            2'd1: begin n = 15; m = 14; end
            2'd2: begin n = 23; m = 18; end
            default: begin n = 31; m = 28; end
        endcase
    endfunction

    function automatic int sat_add(input int a, input int b, input int max);
        return (a + b > max) ? max : a + b;
    endfunction

    always @(posedge clk) begin
        int n, m;
        bit e;
        if (reset) begin
            mq.delete();
            for (int j = 0; j < 31; j++) mq.push_back(1'b0);
            m_locked = 0; m_flag = 0; m_clean = 0; m_dirty = 0;
            m_cnt16 = 0; m_cnt8 = 0; m_mode = mode;
        end else if (!dis) begin
            taps_of(m_mode, n, m);
            tq = mq;
            m_nerr = 0;
            for (int i = 0; i < W; i++) begin
                e = tq[tq.size() - n] ^ tq[tq.size() - m];
                if (data[i] !== e) m_nerr++;
                tq.push_back(m_locked ? e : data[i]);
            end
            while (tq.size() > 31) void'(tq.pop_front());
            if (mode != m_mode) begin
                m_locked = 0; m_clean = 0; m_dirty = 0; m_flag = 0; m_mode = mode;
            end else begin
                mq = tq;
                if (!m_locked) begin
                    m_flag = 0;
                    m_clean = (m_nerr == 0) ? m_clean + 1 : 0;
                    if (m_clean == 4) begin
                        m_locked = 1; m_clean = 0; m_dirty = 0;
                    end
                end else begin
                    m_flag  = (m_nerr != 0);
                    m_cnt16 = sat_add(m_cnt16, m_nerr, 65535);
                    m_cnt8  = sat_add(m_cnt8, m_nerr, 255);
                    m_dirty = (m_nerr != 0) ? m_dirty + 1 : 0;
                    if (m_dirty == 4) begin
                        m_locked = 0; m_dirty = 0; m_clean = 0;
                    end
                end
                if (clear) begin
                    m_cnt16 = 0; m_cnt8 = 0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("locked16", 32'(locked16), 32'(m_locked));
            chk("flag16",   32'(flag16),   32'(m_flag));
            chk("cnt16",    32'(cnt16),    32'(m_cnt16));
            chk("locked8",  32'(locked8),  32'(m_locked));
            chk("flag8",    32'(flag8),    32'(m_flag));
            chk("cnt8",     32'(cnt8),     32'(m_cnt8));
        end
    end

    // ---------------- stimulus generator ----------------
    bit gq[$];
    int gen_n, gen_m;
    logic [1:0] cur_mode;

    task automatic seed_prbs31();
        logic [30:0] s;
        s = 31'h2AAAAAAA;
        gq.delete();
        for (int j = 0; j < 31; j++) gq.push_back(s[j]);
        gen_n = 31; gen_m = 28; cur_mode = 2'd3;
    endtask

    task automatic seed_prbs7();
        gq.delete();
        for (int j = 0; j < 31; j++) gq.push_back(1'b1);
        gen_n = 7; gen_m = 6; cur_mode = 2'd0;
    endtask

    task automatic gen_word(output logic [W-1:0] w);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = gq[gq.size() - gen_n] ^ gq[gq.size() - gen_m];
            w[i] = b;
            gq.push_back(b);
            if (gq.size() > 31) void'(gq.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] d, input logic clr, input logic dz,
                         input logic rst, input logic [1:0] md);
        data = d; clear = clr; dis = dz; reset = rst; mode = md;
        @(negedge clk);
    endtask

    task automatic clean_word();
        logic [W-1:0] w;
        gen_word(w);
        drive(w, 1'b0, 1'b0, 1'b0, cur_mode);
    endtask

    task automatic wait_lock(input string name, input int max_words);
        int used;
        used = 0;
        while (locked16 !== 1'b1 && used < max_words) begin
            clean_word();
            used++;
        end
        chk(name, 32'(locked16), 32'd1);
    endtask

    initial begin
        logic [W-1:0] w;
        int snap_cnt;
        reset = 1'b1; dis = 1'b0; clear = 1'b0; mode = 2'd3; data = '0;
        cur_mode = 2'd3;
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        drive('0, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("rst_locked", 32'(locked16), 32'd0);
        chk("rst_flag",   32'(flag16),   32'd0);
        chk("rst_cnt",    32'(cnt16),    32'd0);

        // 1: clean PRBS31, lock by the edge sampling word 6
        seed_prbs31();
        wait_lock("s1_lock_by_word6", 7);
        for (int k = 0; k < 20000; k++) clean_word();
        chk("s1_cnt_zero", 32'(cnt16), 32'd0);
        chk("s1_model_cnt", 32'(m_cnt16), 32'd0);

        // 2: single flipped bit
        gen_word(w);
        drive(w ^ 15'h0020, 1'b0, 1'b0, 1'b0, cur_mode);
        chk("s2_cnt", 32'(cnt16), 32'd1);
        chk("s2_flag", 32'(flag16), 32'd1);
        chk("s2_locked", 32'(locked16), 32'd1);
        clean_word();
        chk("s2_flag_clear", 32'(flag16), 32'd0);

        // 3: four fully inverted words force unlock
        for (int k = 0; k < 4; k++) begin
            gen_word(w);
            drive(w ^ 15'h7FFF, 1'b0, 1'b0, 1'b0, cur_mode);
            if (k == 2) chk("s3_still_locked", 32'(locked16), 32'd1);
        end
        chk("s3_unlocked", 32'(locked16), 32'd0);
        chk("s3_cnt", 32'(cnt16), 32'd61);
        chk("s3_model_cnt", 32'(m_cnt16), 32'd61);
        wait_lock("s3_relock", 3 + 4);

        // 4: alternating single-bit errors saturate the 8-bit counter
        for (int k = 0; k < 600; k++) begin
            gen_word(w);
            if (k % 2 == 0) w = w ^ 15'h0001;
            drive(w, 1'b0, 1'b0, 1'b0, cur_mode);
        end
        chk("s4_cnt8_sat", 32'(cnt8), 32'd255);
        chk("s4_cnt16", 32'(cnt16), 32'd361);
        chk("s4_locked", 32'(locked8), 32'd1);
        gen_word(w);
        drive(w, 1'b1, 1'b0, 1'b0, cur_mode);
        chk("s4_clear8", 32'(cnt8), 32'd0);
        chk("s4_clear16", 32'(cnt16), 32'd0);

        // 5: switch to PRBS7, then freeze
        seed_prbs7();
        gen_word(w);
        chk("s5_gen_prbs7_w0", 32'(w), 32'h3040);
        drive(w, 1'b0, 1'b0, 1'b0, cur_mode);
        chk("s5_unlock", 32'(locked16), 32'd0);
        chk("s5_cnt_kept", 32'(cnt16), 32'd0);
        wait_lock("s5_relock", 10);
        gen_word(w);
        drive(w ^ 15'h0008, 1'b0, 1'b0, 1'b0, cur_mode);
        chk("s5_err_cnt", 32'(cnt16), 32'd1);
        snap_cnt = m_cnt16;
        for (int k = 0; k < 10; k++) begin
            drive(W'($urandom_range(0, 32767)), 1'b1, 1'b1, 1'b0, 2'd2);
            chk("s5_frz_locked", 32'(locked16), 32'd1);
            chk("s5_frz_flag", 32'(flag16), 32'd1);
            chk("s5_frz_cnt", 32'(cnt16), 32'(snap_cnt));
        end
        clean_word();
        chk("s5_resume_flag", 32'(flag16), 32'd0);
        chk("s5_resume_locked", 32'(locked16), 32'd1);

        // 6: one-cycle reset mid-lock, back to PRBS31
        drive('0, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("s6_rst_locked", 32'(locked16), 32'd0);
        chk("s6_rst_flag", 32'(flag16), 32'd0);
        chk("s6_rst_cnt", 32'(cnt16), 32'd0);
        seed_prbs31();
        wait_lock("s6_relock", 7);
        for (int k = 0; k < 50; k++) clean_word();
        chk("s6_cnt_zero", 32'(cnt16), 32'd0);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
